// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message padder: state encoding, block
// geometry and the byte-placement helper used when building a block.
package sha1_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CORE_RST = 3'd1,
      FILL     = 3'd2,
      SEND     = 3'd3,
      WAIT     = 3'd4,
      PAD      = 3'd5,
      DONE     = 3'd6
   } state_e;

   localparam int          BLOCK_BITS     = 512;
   localparam int          LEN_FIELD_BITS = 64;
   localparam logic [7:0]  PAD_BYTE       = 8'h80;

   // Write one byte into a block; byte 0 occupies the most significant bits.
   function automatic logic [BLOCK_BITS-1:0] put_byte(
      input logic [BLOCK_BITS-1:0] blk,
      input logic [5:0]            pos,
      input logic [7:0]            val
   );
      logic [BLOCK_BITS-1:0] res;
      logic [8:0]            hi;
      res = blk;
      hi  = 9'd511 - {pos, 3'b000};
      res[hi -: 8] = val;
      return res;
   endfunction

endpackage

// File: rtl/sha1_padder.sv
// Byte-stream to 512-bit block padder for a SHA-1 core. Collects message
// bytes, appends the 0x80 marker, zero fill and 64-bit bit length, and hands
// each block to the core with a feed pulse, waiting for the core's done edge.
module sha1_padder
   import sha1_pkg::*;
#(
   parameter int LEN_W      = 16,
   parameter int RST_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  sha_reset,
   output logic                  sha_feed,
   output logic [BLOCK_BITS-1:0] sha_message,
   input  logic                  sha_done,
   output logic                  msg_done,
   output logic                  busy,
   output logic                  len_err
);

   localparam int               RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
   localparam logic [RC_W-1:0]  RC_ONE   = {{(RC_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] CNT_MAX  = {LEN_W{1'b1}};
   localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   state_e                  state_q,     state_d;
   logic [RC_W-1:0]         rst_cnt_q,   rst_cnt_d;
   logic [5:0]              idx_q,       idx_d;
   logic [6:0]              pad_n_q,     pad_n_d;
   logic [LEN_W-1:0]        byte_cnt_q,  byte_cnt_d;
   logic                    len_err_q,   len_err_d;
   logic [BLOCK_BITS-1:0]   blk_q,       blk_d;
   logic                    final_q,     final_d;
   logic                    tail_q,      tail_d;
   logic                    done_prev_q, done_prev_d;
   logic                    in_ready_q,  in_ready_d;
   logic                    sha_reset_q, sha_reset_d;
   logic                    sha_feed_q,  sha_feed_d;
   logic                    msg_done_q,  msg_done_d;
   logic                    busy_q,      busy_d;

   logic                      done_rise_s;
   logic [LEN_FIELD_BITS-1:0] len_field_s;

   // A done edge only counts if sha_done was low on the previous cycle.
   assign done_rise_s = sha_done & ~done_prev_q;
   // Message length in bits, taken from the (saturating) byte count.
   assign len_field_s = {{(LEN_FIELD_BITS-LEN_W-3){1'b0}}, byte_cnt_q, 3'b000};

   // Next-state and datapath update for the padding sequencer.
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      idx_d       = idx_q;
      pad_n_d     = pad_n_q;
      byte_cnt_d  = byte_cnt_q;
      len_err_d   = len_err_q;
      blk_d       = blk_q;
      final_d     = final_q;
      tail_d      = tail_q;
      done_prev_d = sha_done;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d   = CORE_RST;
               rst_cnt_d = {RC_W{1'b0}};
            end else begin
               state_d   = IDLE;
            end
         end

         CORE_RST: begin
            byte_cnt_d = {LEN_W{1'b0}};
            idx_d      = 6'd0;
            pad_n_d    = 7'd0;
            len_err_d  = 1'b0;
            blk_d      = {BLOCK_BITS{1'b0}};
            final_d    = 1'b0;
            tail_d     = 1'b0;
            if (rst_cnt_q == RST_LAST) begin
               state_d = FILL;
            end else begin
               rst_cnt_d = rst_cnt_q + RC_ONE;
            end
         end

         FILL: begin
            if (in_valid) begin
               blk_d = put_byte(blk_q, idx_q, in_data);
               if (byte_cnt_q == CNT_MAX) begin
                  len_err_d = 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q + CNT_ONE;
               end
               if (in_last) begin
                  pad_n_d = {1'b0, idx_q} + 7'd1;
                  state_d = PAD;
               end else if (idx_q == 6'd63) begin
                  final_d = 1'b0;
                  tail_d  = 1'b0;
                  state_d = SEND;
               end else begin
                  idx_d   = idx_q + 6'd1;
               end
            end else begin
               state_d = FILL;
            end
         end

         PAD: begin
            state_d = SEND;
            if (tail_q) begin
               // Extra block: only the length, plus the marker when the data
               // ended exactly on a block boundary.
               blk_d = {BLOCK_BITS{1'b0}};
               if (pad_n_q == 7'd64) begin
                  blk_d[BLOCK_BITS-1 -: 8] = PAD_BYTE;
               end else begin
                  blk_d[BLOCK_BITS-1 -: 8] = 8'h00;
               end
               blk_d[LEN_FIELD_BITS-1:0] = len_field_s;
               final_d = 1'b1;
               tail_d  = 1'b0;
            end else if (pad_n_q <= 7'd55) begin
               blk_d = put_byte(blk_q, pad_n_q[5:0], PAD_BYTE);
               blk_d[LEN_FIELD_BITS-1:0] = len_field_s;
               final_d = 1'b1;
            end else if (pad_n_q <= 7'd63) begin
               blk_d   = put_byte(blk_q, pad_n_q[5:0], PAD_BYTE);
               final_d = 1'b0;
               tail_d  = 1'b1;
            end else begin
               final_d = 1'b0;
               tail_d  = 1'b1;
            end
         end

         SEND: begin
            state_d = WAIT;
         end

         WAIT: begin
            if (done_rise_s) begin
               if (final_q) begin
                  state_d = DONE;
               end else if (tail_q) begin
                  state_d = PAD;
               end else begin
                  state_d = FILL;
                  blk_d   = {BLOCK_BITS{1'b0}};
                  idx_d   = 6'd0;
               end
            end else begin
               state_d = WAIT;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered alongside the state they belong to.
      in_ready_d  = (state_d == FILL);
      sha_reset_d = (state_d == CORE_RST);
      sha_feed_d  = (state_d == SEND);
      msg_done_d  = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers; reset holds the core in reset and clears all.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rst_cnt_q   <= {RC_W{1'b0}};
         idx_q       <= 6'd0;
         pad_n_q     <= 7'd0;
         byte_cnt_q  <= {LEN_W{1'b0}};
         len_err_q   <= 1'b0;
         blk_q       <= {BLOCK_BITS{1'b0}};
         final_q     <= 1'b0;
         tail_q      <= 1'b0;
         done_prev_q <= 1'b0;
         in_ready_q  <= 1'b0;
         sha_reset_q <= 1'b1;
         sha_feed_q  <= 1'b0;
         msg_done_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         idx_q       <= idx_d;
         pad_n_q     <= pad_n_d;
         byte_cnt_q  <= byte_cnt_d;
         len_err_q   <= len_err_d;
         blk_q       <= blk_d;
         final_q     <= final_d;
         tail_q      <= tail_d;
         done_prev_q <= done_prev_d;
         in_ready_q  <= in_ready_d;
         sha_reset_q <= sha_reset_d;
         sha_feed_q  <= sha_feed_d;
         msg_done_q  <= msg_done_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign sha_reset   = sha_reset_q;
   assign sha_feed    = sha_feed_q;
   assign sha_message = blk_q;
   assign msg_done    = msg_done_q;
   assign busy        = busy_q;
   assign len_err     = len_err_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder. Two instances share the input stream
// and done handshake: one with the default counter width and one narrow
// (LEN_W=6) instance that exercises length saturation. Expected blocks come
// from a byte-queue model of standard SHA-1 padding.
module tb_sha1_padder;

   typedef logic [511:0] blk_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       sha_done = 1'b0;

   logic in_ready, sha_reset, sha_feed, msg_done, busy, len_err;
   blk_t sha_message;
   logic s_in_ready, s_sha_reset, s_sha_feed, s_msg_done, s_busy, s_len_err;
   blk_t s_sha_message;

   int   n_checks = 0;
   int   n_errors = 0;
   int   feeds    = 0;
   int   acks     = 0;
   int   done_cnt = 0;
   int   rst_run  = 0;
   blk_t held_msg;
   blk_t last_main;
   blk_t exp_main[$];
   blk_t exp_small[$];
   logic [7:0] msg_bytes[$];

   always #5 clk = ~clk;

   sha1_padder u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .sha_reset(sha_reset),
      .sha_feed(sha_feed), .sha_message(sha_message), .sha_done(sha_done),
      .msg_done(msg_done), .busy(busy), .len_err(len_err)
   );

   sha1_padder #(.LEN_W(6)) u_dut_small (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(s_in_ready), .sha_reset(s_sha_reset),
      .sha_feed(s_sha_feed), .sha_message(s_sha_message), .sha_done(sha_done),
      .msg_done(s_msg_done), .busy(s_busy), .len_err(s_len_err)
   );

   task automatic check_eq(input string tag, input blk_t got, input blk_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian
   // bit length (byte count capped at cap), split into 64-byte blocks.
   function automatic void model_push(input int unsigned cap, input bit to_small);
      logic [7:0]  p[$];
      logic [63:0] bits;
      blk_t        b;
      int unsigned eff;
      p = msg_bytes;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      eff  = (msg_bytes.size() > cap) ? cap : msg_bytes.size();
      bits = 64'(eff) * 64'd8;
      for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
      for (int j = 0; j < p.size(); j += 64) begin
         b = '0;
         for (int m = 0; m < 64; m++) b = {b[503:0], p[j+m]};
         if (to_small) exp_small.push_back(b);
         else          exp_main.push_back(b);
      end
   endfunction

   // Monitor: reset-pulse length, block contents, stability and ordering.
   always begin
      @(negedge clk);
      if (reset_n) begin
         if (sha_reset && busy) begin
            rst_run++;
         end else if (rst_run != 0) begin
            check_eq("rst_cycles", blk_t'(rst_run), blk_t'(4));
            rst_run = 0;
         end
         if (feeds != acks) check_eq("msg_stable", sha_message, held_msg);
         if (sha_feed) begin
            check_eq("feed_after_edge", blk_t'(feeds != acks), blk_t'(0));
            check_eq("blk_avail", blk_t'(exp_main.size() > 0), blk_t'(1));
            if (exp_main.size() > 0) check_eq("blk_main", sha_message, exp_main.pop_front());
            check_eq("feed_sync", blk_t'(s_sha_feed), blk_t'(1));
            if (exp_small.size() > 0) check_eq("blk_small", s_sha_message, exp_small.pop_front());
            held_msg  = sha_message;
            last_main = sha_message;
            feeds++;
         end
         if (msg_done) begin
            check_eq("done_after_edge", blk_t'(feeds != acks), blk_t'(0));
            check_eq("blocks_left", blk_t'(exp_main.size()), blk_t'(0));
            done_cnt++;
         end
      end
   end

   // Core stand-in: after each feed, drop done (it may still be high from the
   // previous block), then raise it again to acknowledge.
   always begin
      @(negedge clk);
      if (reset_n && sha_feed) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         sha_done = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         if (reset_n) sha_done = 1'b1;
         acks = feeds;
      end
   end

   task automatic fill_random(input int len);
      msg_bytes.delete();
      for (int k = 0; k < len; k++) msg_bytes.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic drive_bytes();
      int i      = 0;
      int budget = 0;
      exp_main.delete();
      exp_small.delete();
      model_push(32'd65535, 1'b0);
      model_push(32'd63, 1'b1);
      while (i < msg_bytes.size() && budget < 4000) begin
         @(negedge clk);
         budget++;
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = msg_bytes[i];
         in_last  = (i == msg_bytes.size() - 1);
         if (in_valid && in_ready) i++;
      end
      check_eq("bytes_accepted", blk_t'(i), blk_t'(msg_bytes.size()));
   endtask

   task automatic run_msg();
      int d0     = done_cnt;
      int budget = 0;
      drive_bytes();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      while (done_cnt == d0 && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      check_eq("msg_done_seen", blk_t'(done_cnt != d0), blk_t'(1));
      check_eq("len_err_main", blk_t'(len_err), blk_t'(0));
      check_eq("len_err_small", blk_t'(s_len_err), blk_t'(msg_bytes.size() > 63));
      @(negedge clk);
      check_eq("idle_busy", blk_t'(busy), blk_t'(0));
      check_eq("done_pulse", blk_t'(msg_done), blk_t'(0));
   endtask

   task automatic reset_mid_wait();
      int budget = 0;
      fill_random(60);
      drive_bytes();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      while (!sha_feed && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check_eq("first_feed_seen", blk_t'(sha_feed), blk_t'(1));
      @(negedge clk);
      check_eq("in_wait_ready", blk_t'(in_ready), blk_t'(0));
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("rst_sha_reset", blk_t'(sha_reset), blk_t'(1));
      check_eq("rst_feed", blk_t'(sha_feed), blk_t'(0));
      check_eq("rst_message", sha_message, blk_t'(0));
      check_eq("rst_ready", blk_t'(in_ready), blk_t'(0));
      check_eq("rst_msg_done", blk_t'(msg_done), blk_t'(0));
      check_eq("rst_busy", blk_t'(busy), blk_t'(0));
      repeat (8) @(negedge clk);
      reset_n = 1'b1;
      exp_main.delete();
      exp_small.delete();
      @(negedge clk);
      check_eq("post_rst_sha_reset", blk_t'(sha_reset), blk_t'(0));
      repeat (4) @(negedge clk);
   endtask

   initial begin
      blk_t abc_blk;
      int   lens[6];
      abc_blk = {32'h61626380, 416'h0, 64'h18};
      lens    = '{55, 56, 63, 64, 128, 1};

      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_sha_reset", blk_t'(sha_reset), blk_t'(1));
      check_eq("reset_feed", blk_t'(sha_feed), blk_t'(0));
      check_eq("reset_message", sha_message, blk_t'(0));
      check_eq("reset_ready", blk_t'(in_ready), blk_t'(0));
      check_eq("reset_msg_done", blk_t'(msg_done), blk_t'(0));
      check_eq("reset_busy", blk_t'(busy), blk_t'(0));
      check_eq("reset_len_err", blk_t'(len_err), blk_t'(0));
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("release_sha_reset", blk_t'(sha_reset), blk_t'(0));
      check_eq("release_busy", blk_t'(busy), blk_t'(0));

      msg_bytes = '{8'h61, 8'h62, 8'h63};
      run_msg();
      check_eq("abc_block", last_main, abc_blk);

      foreach (lens[k]) begin
         fill_random(lens[k]);
         run_msg();
      end
      for (int r = 0; r < 4; r++) begin
         fill_random($urandom_range(1, 150));
         run_msg();
      end

      reset_mid_wait();
      msg_bytes = '{8'h61, 8'h62, 8'h63};
      run_msg();
      check_eq("abc_after_reset", last_main, abc_blk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
